// File: rtl/bec_pkg.sv
// bec_pkg: shared widths, engine load_status slots, becStatus bits and sequencer states
package bec_pkg;
   localparam int WIDTH = 163;
   localparam int KEY_BITS = 163;
   localparam int IDX_W = $clog2(KEY_BITS);
   localparam int CNT_W = $clog2(KEY_BITS + 1);
   localparam logic [2:0] LS_X = 3'b000;
   localparam logic [2:0] LS_Z = 3'b001;
   localparam logic [2:0] LS_X2 = 3'b010;
   localparam logic [2:0] LS_Z2 = 3'b011;
   localparam logic [2:0] LS_INVW0 = 3'b100;
   localparam logic [2:0] LS_D = 3'b101;
   localparam int BS_UPLOAD = 0;
   localparam int BS_PROC = 1;
   localparam int BS_DOWNLOAD = 2;
   localparam int BS_IDLE = 3;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_KICK, S_RUN, S_UNLD_X, S_UNLD_Z} state_t;
endpackage

// File: rtl/bec_wdog.sv
// bec_wdog: saturating no-progress counter; timeout holds while the count sits at all-ones
module bec_wdog #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic kick,
   output logic timeout
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (!en || kick) ? '0 : cnt + W'(!timeout);
   assign timeout = &cnt;
endmodule

// File: rtl/bec_seq_ctrl.sv
// bec_seq_ctrl: host sequencer running a full sm_bec_v3 transaction (request, download, run, upload)
module bec_seq_ctrl
   import bec_pkg::*;
#(
   parameter int WDOG_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [WIDTH-1:0] cfg_wdata,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] res_x,
   output logic [WIDTH-1:0] res_z,
   output logic             bec_load_data,
   output logic [2:0]       bec_load_status,
   output logic [WIDTH-1:0] bec_data_in,
   output logic             bec_trig_load,
   output logic             bec_ki,
   output logic             bec_enable,
   input  logic             bec_next_key,
   input  logic [3:0]       bec_status,
   input  logic             bec_done,
   input  logic [WIDTH-1:0] bec_data_out
);
   state_t st, nxt;
   logic [WIDTH-1:0] opr [6];
   logic [WIDTH-1:0] key;
   logic [2:0] slot;
   logic ph;
   logic [IDX_W-1:0] key_idx, idx_dec;
   logic [CNT_W-1:0] pcnt;
   logic to, wd_en, wd_kick, bad_cnt, unused_status;

   assign unused_status = ^{bec_status[BS_IDLE], bec_status[BS_PROC], bec_status[BS_UPLOAD]};
   assign idx_dec = (key_idx == '0) ? '0 : key_idx - 1'b1;
   assign bad_cnt = bec_done && pcnt != CNT_W'(KEY_BITS);
   assign wd_en = st inside {S_REQ, S_RUN, S_UNLD_X, S_UNLD_Z};
   assign wd_kick = (nxt != st) || bec_next_key || bec_done;

   bec_wdog #(.W(WDOG_W)) u_wdog (
      .clk(clk), .rst_n(rst_n), .en(wd_en), .kick(wd_kick), .timeout(to)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= S_IDLE;
      else st <= nxt;

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:   nxt = start ? S_REQ : S_IDLE;
         S_REQ:    nxt = to ? S_IDLE : bec_status[BS_DOWNLOAD] ? S_LOAD : S_REQ;
         S_LOAD:   nxt = (ph && slot == LS_D) ? S_KICK : S_LOAD;
         S_KICK:   nxt = S_RUN;
         S_RUN:    nxt = (to || bad_cnt) ? S_IDLE : bec_done ? S_UNLD_X : S_RUN;
         S_UNLD_X: nxt = to ? S_IDLE : S_UNLD_Z;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = st != S_IDLE;
      bec_load_data = st == S_REQ;
      bec_trig_load = st == S_LOAD && !ph;
      bec_enable = st == S_KICK;
      bec_load_status = (st == S_LOAD) ? slot : (st == S_UNLD_Z) ? LS_Z : LS_X;
      bec_data_in = (st == S_LOAD) ? opr[slot] : '0;
   end

   // ki is registered so each new key bit is stable for the engine's next st0 cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) opr[i] <= '0;
         key <= '0;
         slot <= '0;
         ph <= 1'b0;
         key_idx <= IDX_W'(KEY_BITS - 1);
         pcnt <= '0;
         bec_ki <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         res_x <= '0;
         res_z <= '0;
      end else begin
         if (st == S_IDLE && cfg_we && cfg_addr < 3'd6) opr[cfg_addr] <= cfg_wdata;
         if (st == S_IDLE && cfg_we && cfg_addr == 3'd6) key <= cfg_wdata;
         slot <= (st == S_LOAD) ? slot + {2'b0, ph} : '0;
         ph <= st == S_LOAD && !ph;
         done <= st == S_UNLD_Z;
         err <= (st == S_IDLE && start) ? 1'b0 : err || (wd_en && to) || (st == S_RUN && bad_cnt);
         if (st == S_UNLD_X) res_x <= bec_data_out;
         if (st == S_UNLD_Z) res_z <= bec_data_out;
         if (st == S_IDLE) begin
            key_idx <= IDX_W'(KEY_BITS - 1);
            pcnt <= '0;
            bec_ki <= start && key[KEY_BITS-1];
         end else if (nxt == S_IDLE) begin
            bec_ki <= 1'b0;
         end else if (st == S_RUN && bec_next_key) begin
            key_idx <= idx_dec;
            pcnt <= pcnt + CNT_W'(pcnt != '1);
            bec_ki <= key[idx_dec];
         end
      end
endmodule

// File: tb/tb_bec_seq_ctrl.sv
// tb_bec_seq_ctrl: engine model plus scoreboard queues for loads, key bits and results
module tb_bec_seq_ctrl;
   import bec_pkg::*;
   localparam int WD = 8;
   localparam int TO = (1 << WD) - 1;

   typedef struct {logic [2:0] slot; logic [WIDTH-1:0] data;} ld_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [WIDTH-1:0] cfg_wdata = '0;
   logic start = 1'b0;
   logic busy, done, err, bec_load_data, bec_trig_load, bec_ki, bec_enable;
   logic [WIDTH-1:0] res_x, res_z, bec_data_in, bec_data_out;
   logic [2:0] bec_load_status;
   logic bec_next_key = 1'b0;
   logic bec_done = 1'b0;
   logic [3:0] bec_status = 4'b1000;

   ld_t ld_q[$];
   logic ki_q[$];
   logic [WIDTH-1:0] rx_q[$], rz_q[$];
   ld_t e_ld;
   logic e_ki, ld_ki;
   logic [WIDTH-1:0] ex, ez, ra, rb, tkey;
   logic [WIDTH-1:0] ops [6];
   int n_chk = 0, n_fail = 0, n_done = 0;
   int m_st = 0, m_w = 0, m_pulses = 0, m_n = KEY_BITS;
   bit m_ph = 0, m_stall = 0;

   bec_seq_ctrl #(.WDOG_W(WD)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .busy(busy), .done(done), .err(err), .res_x(res_x), .res_z(res_z),
      .bec_load_data(bec_load_data), .bec_load_status(bec_load_status), .bec_data_in(bec_data_in),
      .bec_trig_load(bec_trig_load), .bec_ki(bec_ki), .bec_enable(bec_enable),
      .bec_next_key(bec_next_key), .bec_status(bec_status), .bec_done(bec_done),
      .bec_data_out(bec_data_out)
   );

   always #5 clk = ~clk;

   assign bec_data_out = (bec_load_status == LS_Z) ? rb : ra;

   // engine model: request handshake, download checking, key-bit consumption, upload
   always @(negedge clk)
      if (!busy) begin
         m_st = 0;
         bec_next_key = 1'b0;
         bec_done = 1'b0;
         bec_status = 4'b1000;
      end else case (m_st)
         0: if (bec_load_data) begin m_st = 1; m_w = 3; end
         1: begin
            m_w--;
            if (m_w == 0) begin bec_status = 4'b0100; m_st = 2; end
         end
         2: begin
            if (bec_trig_load) begin
               n_chk++;
               if (ld_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL load_extra: got slot %0d, expected no load", bec_load_status);
               end else begin
                  e_ld = ld_q.pop_front();
                  if (bec_load_status !== e_ld.slot || bec_data_in !== e_ld.data || bec_ki !== ld_ki) begin
                     n_fail++;
                     $display("FAIL load: got slot %0d data %h ki %b, expected slot %0d data %h ki %b",
                              bec_load_status, bec_data_in, bec_ki, e_ld.slot, e_ld.data, ld_ki);
                  end
               end
            end
            if (bec_enable) begin m_st = 3; m_ph = 0; m_pulses = 0; bec_status = 4'b0010; end
         end
         3: if (!m_stall) begin
            if (!m_ph) begin
               if (m_pulses < m_n) begin
                  n_chk++;
                  if (ki_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL ki_extra: got ki %b at pulse %0d, expected none", bec_ki, m_pulses);
                  end else begin
                     e_ki = ki_q.pop_front();
                     if (bec_ki !== e_ki) begin
                        n_fail++;
                        $display("FAIL ki: pulse %0d got %b, expected %b", m_pulses, bec_ki, e_ki);
                     end
                  end
                  bec_next_key = 1'b1;
                  m_pulses++;
               end else begin
                  bec_done = 1'b1;
                  bec_status = 4'b0001;
               end
            end else begin
               bec_next_key = 1'b0;
               if (bec_done) begin bec_done = 1'b0; m_st = 4; end
            end
            m_ph = !m_ph;
         end
         default: ;
      endcase

   always @(negedge clk)
      if (done) begin
         n_done++;
         n_chk++;
         if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: got done with res_x %h, expected no done", res_x);
         end else begin
            ex = rx_q.pop_front();
            ez = rz_q.pop_front();
            if (res_x !== ex || res_z !== ez || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL done_result: got x %h z %h busy %b, expected x %h z %h busy 0",
                        res_x, res_z, busy, ex, ez);
            end
         end
      end

   task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic go();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic load_all();
      logic [2:0] kk;
      for (int k = 0; k < 6; k++) begin
         kk = 3'(k);
         ops[k] = {WIDTH{^kk}} ^ WIDTH'(k);
         wr(kk, ops[k]);
      end
   endtask

   // expected loads, then the key bits the engine will consume (first one is the MSB latched at start)
   task automatic push_txn(input int n, input logic first_bit);
      ld_ki = first_bit;
      m_n = n;
      for (int k = 0; k < 6; k++) ld_q.push_back('{3'(k), ops[k]});
      for (int i = 0; i < n; i++) ki_q.push_back(i == 0 ? first_bit : tkey[KEY_BITS-1-i]);
   endtask

   task automatic push_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
      ra = x; rb = z;
      rx_q.push_back(x);
      rz_q.push_back(z);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while (busy && c < 3000) begin @(negedge clk); c++; end
      #1;
      n_chk++;
      if (busy) begin n_fail++; $display("FAIL %s_timeout: busy still %b, expected 0", tag, busy); end
   endtask

   task automatic check_drained(input string tag);
      n_chk++;
      if (ld_q.size() != 0 || ki_q.size() != 0 || rx_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drained: got pending loads %0d ki %0d res %0d, expected 0 0 0",
                  tag, ld_q.size(), ki_q.size(), rx_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if ({busy, done, err, bec_load_data, bec_trig_load, bec_ki, bec_enable, bec_load_status} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, expected 0", {busy, done, err, bec_load_data, bec_trig_load,
                  bec_ki, bec_enable, bec_load_status});
      end
      n_chk++;
      if (res_x !== '0 || res_z !== '0 || bec_data_in !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got x %h z %h din %h, expected 0", res_x, res_z, bec_data_in);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_key_one();
      load_all();
      tkey = WIDTH'(1);
      wr(3'd6, tkey);
      push_res(WIDTH'(64'h5_1234_5678), WIDTH'(64'h9_8765_4321));
      push_txn(KEY_BITS, tkey[KEY_BITS-1]);
      n_done = 0;
      go();
      wait_idle("key_one");
      check_drained("key_one");
      n_chk++;
      if (n_done != 1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL key_one_done: got done %0d err %b, expected 1 0", n_done, err);
      end
   endtask

   task automatic test_all_ones();
      tkey = '1;
      wr(3'd6, tkey);
      push_res(WIDTH'(12'hABC), WIDTH'(12'h123));
      push_txn(KEY_BITS, 1'b1);
      n_done = 0;
      go();
      wait_idle("all_ones");
      check_drained("all_ones");
      n_chk++;
      if (res_x !== WIDTH'(12'hABC) || res_z !== WIDTH'(12'h123) || n_done != 1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL all_ones: got x %h z %h done %0d err %b, expected abc 123 1 0", res_x, res_z, n_done, err);
      end
   endtask

   task automatic test_busy_write();
      int c = 0;
      push_res(WIDTH'(16'h1111), WIDTH'(16'h2222));
      push_txn(KEY_BITS, tkey[KEY_BITS-1]);
      go();
      while (m_st != 3 && c < 500) begin @(negedge clk); #1; c++; end
      wr(3'd3, WIDTH'(32'hDEAD_BEEF));
      wait_idle("busy_write_a");
      // second run: slot 3 must still hold the old pattern; key rewritten in the start cycle
      push_res(WIDTH'(16'h3333), WIDTH'(16'h4444));
      tkey = {1'b0, {(WIDTH-1){1'b1}}};
      push_txn(KEY_BITS, 1'b1);
      n_done = 0;
      @(negedge clk);
      start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = tkey;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      wait_idle("busy_write_b");
      check_drained("busy_write");
      n_chk++;
      if (n_done != 1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_write_done: got done %0d err %b, expected 1 0", n_done, err);
      end
   endtask

   task automatic test_watchdog();
      int c = 0;
      m_stall = 1;
      push_txn(0, 1'b0);
      n_done = 0;
      go();
      while (!bec_enable && c < 500) begin @(negedge clk); c++; end
      c = 0;
      while (busy && c < TO + 50) begin @(negedge clk); c++; end
      #1;
      n_chk++;
      if (c != TO + 2 || err !== 1'b1 || busy !== 1'b0 || n_done != 0) begin
         n_fail++;
         $display("FAIL watchdog: got cycles %0d err %b busy %b done %0d, expected %0d 1 0 0",
                  c, err, busy, n_done, TO + 2);
      end
      check_drained("watchdog");
      m_stall = 0;
      push_res(WIDTH'(20'hA5A5A), WIDTH'(20'h5A5A5));
      push_txn(KEY_BITS, tkey[KEY_BITS-1]);
      go();
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err_clear: got err %b busy %b, expected 0 1", err, busy);
      end
      wait_idle("recover");
      check_drained("recover");
      n_chk++;
      if (n_done != 1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL recover_done: got done %0d err %b, expected 1 0", n_done, err);
      end
   endtask

   task automatic test_early_done();
      push_txn(100, tkey[KEY_BITS-1]);
      n_done = 0;
      go();
      wait_idle("early_done");
      check_drained("early_done");
      n_chk++;
      if (err !== 1'b1 || n_done != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL early_done: got err %b done %0d busy %b, expected 1 0 0", err, n_done, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int c = 0;
      push_txn(KEY_BITS, tkey[KEY_BITS-1]);
      go();
      while (m_pulses != 82 && c < 2000) begin @(negedge clk); #1; c++; end
      @(posedge clk); #1;
      n_chk++;
      if (dut.key_idx !== 8'd80 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_index: got idx %0d busy %b, expected 80 1", dut.key_idx, busy);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, err, bec_load_data, bec_trig_load, bec_ki, bec_enable, bec_load_status} !== '0 ||
          res_x !== '0 || res_z !== '0 || bec_data_in !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got ctrl %b x %h z %h, expected all 0", {busy, done, err, bec_load_data,
                  bec_trig_load, bec_ki, bec_enable, bec_load_status}, res_x, res_z);
      end
      ld_q.delete(); ki_q.delete(); rx_q.delete(); rz_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (dut.key_idx !== 8'd162 || res_x !== '0 || res_z !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: got idx %0d x %h z %h busy %b, expected 162 0 0 0",
                  dut.key_idx, res_x, res_z, busy);
      end
   endtask

   initial begin
      test_reset();
      test_key_one();
      test_all_ones();
      test_busy_write();
      test_watchdog();
      test_early_done();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end
endmodule
